register_file_mp: RTL

//  Multi-port register file for the datapath: NUM_RD combinational read ports, two write ports.

---
 rtl/register_file_mp_if.sv | 31 +++
 rtl/register_file_mp.sv | 119 +++++++++++
 2 files changed

// File: rtl/register_file_mp_if.sv
// Bus interface for register_file_mp: clear control, two write lanes and
// NUM_RD packed read ports. The datapath side drives through "master",
// the register file sits on "slave".
interface register_file_mp_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NUM_RD = 2
);
    logic                     clr_req;
    logic                     busy;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;

    modport master (
        output clr_req, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, rd_addr,
        input  busy, rd_data
    );

    modport slave (
        input  clr_req, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, rd_addr,
        output busy, rd_data
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write
// lanes (lane 1 has priority on a shared address). The array has no reset
// of its own; a clear walks through it one entry per cycle so it can map
// onto distributed RAM. Optional feature macro: RF_BYPASS_EN, which makes a
// read of an address being written this cycle return the write data.
module register_file_mp #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    register_file_mp_if.slave  bus
);

    localparam int                DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = '1;
    localparam bit                ZR    = (ZERO_REG != 0);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W-1:0] clr_ptr_next;
    logic              busy;
    logic              wr0_ok;
    logic              wr1_ok;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_bus;

    assign busy     = (state == CLEAR);
    assign bus.busy = busy;

    assign wr0_ok = bus.wr0_en && !busy && !(ZR && (bus.wr0_addr == '0));
    assign wr1_ok = bus.wr1_en && !busy && !(ZR && (bus.wr1_addr == '0));

    // State and clear pointer registers; reset always (re)starts a full clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Next-state: IDLE accepts a clear request, CLEAR walks the pointer to the last entry.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_next   = CLEAR;
                    clr_ptr_next = '0;
                end
            end
            CLEAR: begin
                clr_ptr_next = clr_ptr + 1'b1;
                if (clr_ptr == LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                clr_ptr_next = '0;
            end
        endcase
    end

    // Array update: clearing owns the array while busy, otherwise lane 1 is written last so it wins.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else begin
            if (wr0_ok) begin
                mem[bus.wr0_addr] <= bus.wr0_data;
            end
            if (wr1_ok) begin
                mem[bus.wr1_addr] <= bus.wr1_data;
            end
        end
    end

    // Combinational read ports with optional write bypass, masked while busy and for hardwired r0.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] word;
        rd_bus = '0;
        ra     = '0;
        word   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra   = bus.rd_addr[k*ADDR_W +: ADDR_W];
            word = mem[ra];
`ifdef RF_BYPASS_EN
            if (wr1_ok && (bus.wr1_addr == ra)) begin
                word = bus.wr1_data;
            end else if (wr0_ok && (bus.wr0_addr == ra)) begin
                word = bus.wr0_data;
            end
`else
            word = mem[ra];
`endif
            if (busy || (ZR && (ra == '0))) begin
                word = '0;
            end
            rd_bus[k*DATA_W +: DATA_W] = word;
        end
    end

    assign bus.rd_data = rd_bus;

endmodule
